// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: multiply/divide opcodes and MDU sequencing states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MDU_MULT,
        MDU_MULTU,
        MDU_DIV,
        MDU_DIVU
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle of the MDU request/response signals as seen from the EX stage.
interface mult_div_unit_if
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport mdu (
        input  start, op, rs, rt, flush,
        output busy, done, div_by_zero, hi, lo
    );

    modport ex (
        output start, op, rs, rt, flush,
        input  busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_datapath.sv
// Shift/accumulate registers for shift-add multiply and restoring divide,
// sharing one (WIDTH+1)-bit add/subtract.
module mdu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] lower
);

    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   addend;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   mult_sel;

    // Divide shifts the next dividend bit into the remainder before the trial
    // subtract; multiply adds the multiplicand into the upper half as-is.
    always_comb begin
        shifted  = is_div ? {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]} : acc_hi;
        addend   = {1'b0, opnd} ^ {(WIDTH+1){is_div}};
        sum      = {1'b0, shifted} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, is_div};
        mult_sel = acc_lo[0] ? sum[WIDTH:0] : shifted;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= b_in;
            opnd   <= a_in;
        end else if (step) begin
            if (is_div) begin
                // Carry out of the subtract means no borrow: the trial fits.
                if (sum[WIDTH+1]) begin
                    acc_hi <= sum[WIDTH:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= shifted;
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= {1'b0, mult_sel[WIDTH:1]};
                acc_lo <= {mult_sel[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    assign upper = acc_hi[WIDTH-1:0];
    assign lower = acc_lo;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers;
// operands are reduced to magnitudes up front and sign-corrected in FIX.
module mult_div_unit
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    mdu_op_t            op_q;
    logic               sign_q, sign_r, dbz_q;
    logic               load, step, write;
    logic               in_signed, in_div, run_div;
    logic [WIDTH-1:0]   a_in, b_in, upper, lower;
    logic [WIDTH-1:0]   hi_fix, lo_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign in_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign in_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign run_div   = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    assign a_in      = (in_signed && rt[WIDTH-1]) ? -rt : rt;
    assign b_in      = (in_signed && rs[WIDTH-1]) ? -rs : rs;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        write   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = CALC;
                    load    = 1'b1;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    write   = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = CALC;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Divide by zero leaves quotient all ones and the dividend in the
    // remainder register, so sign correction is simply skipped.
    always_comb begin
        prod     = {upper, lower};
        prod_fix = sign_q ? -prod : prod;
        if (run_div) begin
            if (dbz_q) begin
                hi_fix = upper;
                lo_fix = '1;
            end else begin
                hi_fix = sign_r ? -upper : upper;
                lo_fix = sign_q ? -lower : lower;
            end
        end else begin
            {hi_fix, lo_fix} = prod_fix;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dbz_q   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q  <= '0;
                op_q   <= op;
                sign_q <= in_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                sign_r <= in_signed && rs[WIDTH-1];
                dbz_q  <= in_div && (rt == '0);
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (write) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end

    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign div_by_zero = done && dbz_q;

    mdu_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .CLK    (CLK),
        .nRST   (nRST),
        .load   (load),
        .step   (step),
        .is_div (run_div),
        .a_in   (a_in),
        .b_in   (b_in),
        .upper  (upper),
        .lower  (lower)
    );

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    mdu_op_t     op = MDU_MULT;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mult_div_unit #(
        .WIDTH(32),
        .CNT_W(5)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (start),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                {eh, el} = p;
            end
            MDU_MULT: begin
                p = 64'(sa * sb);
                {eh, el} = p;
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    eh = a; el = '1; ed = 1'b1;
                end else begin
                    eh = a % b; el = a / b;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    eh = a[31] ? 32'(-sa) : a; el = '1; ed = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    el = 32'(q); eh = 32'(r);
                end
            end
        endcase
    endtask

    // Called #1 after a clock edge with the unit in IDLE or DONE.
    task automatic run_op(input string tag, input mdu_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] eh, el;
        logic ed;
        int cyc;
        bit seen;
        model(o, a, b, eh, el, ed);
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge CLK); #1;
        start = 1'b0; rs = $urandom; rt = $urandom;
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            if (poke && cyc == 4) begin
                start = 1'b1;
                op = mdu_op_t'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
            if (cyc == 1) check({tag, " busy"}, {31'd0, busy}, 32'd1);
            if (done) seen = 1;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'd33);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
        check({tag, " busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_hi, prev_lo, a, b;
        mdu_op_t o;
        int seen_done;

        repeat (3) @(posedge CLK);
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max hi_const", hi, 32'hFFFF_FFFE);
        @(posedge CLK); #1;
        check("done_pulse", {31'd0, done}, 32'd0);

        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 1'b0);
        run_op("div_zero_pos", MDU_DIV, 32'd77, 32'd0, 1'b0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf lo_const", lo, 32'h8000_0000);
        run_op("b2b_poke", MDU_DIVU, 32'd12345, 32'd7, 1'b1);
        @(posedge CLK); #1;

        // Flush mid-calculation
        prev_hi = hi; prev_lo = lo;
        start = 1'b1; op = MDU_MULTU; rs = 32'd5; rt = 32'd6;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (done) seen_done++;
        end
        check("flush no_done", 32'(seen_done), 32'd0);
        check("flush hi", hi, prev_hi);
        check("flush lo", lo, prev_lo);

        start = 1'b1; flush = 1'b1; op = MDU_MULTU; rs = 32'd9; rt = 32'd9;
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", {31'd0, busy}, 32'd0);
        @(posedge CLK); #1;
        check("flush_start done", {31'd0, done}, 32'd0);
        check("flush_start lo", lo, prev_lo);

        // Reset mid-divide
        start = 1'b1; op = MDU_DIV; rs = 32'hDEAD_BEEF; rt = 32'd13;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (19) @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(posedge CLK); #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;
        run_op("after_rst", MDU_MULTU, 32'd3, 32'd4, 1'b0);
        check("after_rst lo_const", lo, 32'd12);

        for (int n = 0; n < 40; n++) begin
            o = mdu_op_t'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(1, 20);
                1: a = 32'h8000_0000;
                2: if (o == MDU_DIVU) b = 32'd0;
                3: a = $urandom_range(0, 50);
                default: ;
            endcase
            run_op("rand", o, a, b, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge CLK); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- It takes the same register operands the ALU receives on PORTA/PORTB and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Results go into architectural HI/LO registers, which the EX result mux reads for MFHI/MFLO.
- The hazard unit uses busy to stall the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- CLK  in  1  rising-edge clock
- nRST  in  1  synchronous, active-low reset
- start  in  1  request a new operation; sampled only in IDLE or DONE
- op  in  mdu_op_t (2)  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
- rs  in  32  multiplicand or dividend
- rt  in  32  multiplier or divisor
- flush  in  1  abort the in-flight operation (branch squash)
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse in DONE
- div_by_zero  out  1  valid with done; high if a div op had rt==0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: all actions are synchronous on CLK when nRST=0. state=IDLE, hi=lo=0, busy=done=div_by_zero=0, counter=0. Reset mid-operation aborts it with no HI/LO update.
- States: IDLE, CALC, FIX, DONE.
  - IDLE/DONE and start=1 → CALC. Latch op. Latch |rs| and |rt| (signed ops) or raw rs and rt (unsigned ops). Latch sign_q = rs[31]^rt[31] and sign_r = rs[31] (signed ops only). Clear the accumulator; counter=0.
  - IDLE with start=0 → IDLE. DONE with start=0 → IDLE.
  - CALC: one iteration per cycle. Counter increments. At counter==WIDTH-1 → FIX.
    - Multiply: shift-add, 64-bit product accumulated.
    - Divide: restoring, one quotient bit per cycle.
  - FIX: sign correction, then → DONE and hi/lo written at this edge.
    - Mult: {hi,lo} = 64-bit product, negated if signed and sign_q=1.
    - Div: lo = quotient, negated if signed and sign_q=1. hi = remainder, negated if signed and sign_r=1.
  - DONE: done=1 for exactly one cycle, busy=0.
- Latency: start sampled at edge k → CALC iterations on edges k+1..k+32 → FIX→DONE at edge k+33. done is high during cycle k+33..k+34. Back-to-back start in DONE is accepted.
- start while busy=1 is ignored. Operand inputs are not re-sampled after edge k.
- flush=1 in CALC or FIX → IDLE next edge. hi/lo are unchanged and done is not pulsed. flush in IDLE or DONE has no effect. flush together with start in IDLE: flush wins and no operation starts.
- Divide by zero (DIV/DIVU, rt==0): full latency. Result hi=rs as latched (unsigned value), lo=32'hFFFF_FFFF, div_by_zero=1 with done.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. No overflow flag; wrap-around is the defined result.
- hi/lo hold their value except at the FIX→DONE edge. No other write path exists; MTHI/MTLO are out of scope.
- Arithmetic: the magnitude of -2^31 is treated as the unsigned value 2^31 (33-bit internal operands are permitted). The product accumulator is 64 bits. The divide remainder register is 33 bits.

Decomposition:
- Add to cpu_types_pkg:
  - typedef enum logic [1:0] mdu_op_t {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}
  - typedef enum logic [1:0] mdu_state_t {IDLE, CALC, FIX, DONE}
- Declare a mult_div_unit_if interface, following the convention the ALU uses for its interface, with modport mdu.
- One natural sub-module: mdu_datapath. It holds the shift/accumulate registers and a single 33-bit add/subtract shared by multiply and divide. The FSM and counter stay in mult_div_unit.

Test Plan:
- MULTU rs=0xFFFF_FFFF, rt=0xFFFF_FFFF → done at cycle 34 after start; hi=0xFFFF_FFFE, lo=0x0000_0001.
- MULT rs=0xFFFF_FFFD (-3), rt=7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (-21). DIV rs=-7, rt=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- DIVU rs=100, rt=0 → full latency; div_by_zero=1 with done; hi=100, lo=0xFFFF_FFFF.
- DIV rs=0x8000_0000, rt=0xFFFF_FFFF → lo=0x8000_0000, hi=0. A second start presented in DONE is accepted, and its done pulse arrives 34 cycles later.
- Start MULTU 5×6, flush at cycle 10 → busy drops next cycle, no done pulse, hi/lo keep their prior values. A start during CALC is ignored (latched operands unchanged).
- nRST=0 asserted at cycle 20 of a DIV → next edge: state IDLE, hi=lo=0, busy=0. Release nRST, then MULTU 3×4 → lo=12, hi=0.
